// File: rtl/wb_sdram_bridge.sv
// wb_sdram_bridge
// Wishbone slave front end for the SDRAM controller request port.
// Writes are posted into a small FIFO and acked one cycle after the request.
// Reads wait until every posted write has been sent to the controller. Only
// one read may be outstanding at a time. A read that gets no data in time is
// completed with 32'hDEAD_BEEF and sets a sticky error flag.
//
// Ports
//   clk, rst              single clock, asynchronous active-high reset
//   wbs_*                 Wishbone slave (stb/cyc/we/sel/dat/adr in, ack/dat out)
//   ctrl_addr/rw/data_in/mask/in_valid   request to the controller
//   ctrl_busy             controller cannot take a request this cycle
//   ctrl_data_out/out_valid              read data strobe from the controller
//   wr_level              number of posted writes not yet sent
//   rd_timeout_err        sticky read-timeout flag, cleared only by rst
//
// Handshake: a controller request transfers on any cycle where
// ctrl_in_valid=1 and ctrl_busy=0. While ctrl_in_valid is high, the request
// fields stay stable until that transfer happens. ctrl_out_valid is a
// one-cycle strobe with no back-pressure.
module wb_sdram_bridge #(
  parameter int ADDR_W     = 23,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT = 1023,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = PTR_W + 1,
  localparam int TMR_W     = $clog2(RD_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rw,
  output logic [31:0]       ctrl_data_in,
  output logic [3:0]        ctrl_mask,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  input  logic [31:0]       ctrl_data_out,
  input  logic              ctrl_out_valid,
  output logic [LVL_W-1:0]  wr_level,
  output logic              rd_timeout_err
);

  typedef enum logic [1:0] {IDLE, DRAIN, RD_ISSUE, RD_WAIT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [3:0]        fifo_sel  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [TMR_W-1:0]  timer;

  logic req, rd_req, push, pop, fifo_empty, fifo_full, drain_ok;
  logic tmo_hit, rd_done, rd_tmo;

  // Upper address bits are outside the controller's word space.
  logic unused_adr;
  assign unused_adr = ^wbs_adr_i[31:ADDR_W];

  // The ack cycle itself never starts a new transaction.
  assign req        = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign fifo_empty = (wr_level == '0);
  assign fifo_full  = (wr_level == LVL_W'(FIFO_DEPTH));
  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign push       = (state == IDLE) & req & wbs_we_i & ~fifo_full;
  assign rd_req     = (state == IDLE) & req & ~wbs_we_i;
  // The FIFO head is offered to the controller except while a read owns it.
  assign drain_ok   = ~fifo_empty & (state != RD_ISSUE) & (state != RD_WAIT);
  assign pop        = drain_ok & ~ctrl_busy;
  assign tmo_hit    = (timer == TMR_W'(RD_TIMEOUT));
  // On the timeout cycle, real data takes priority over the error completion.
  assign rd_done    = (state == RD_WAIT) & (ctrl_out_valid | tmo_hit);
  assign rd_tmo     = (state == RD_WAIT) & ~ctrl_out_valid & tmo_hit;

  always_comb begin
    state_next    = state;
    ctrl_in_valid = 1'b0;
    ctrl_rw       = 1'b0;
    ctrl_addr     = '0;
    ctrl_data_in  = '0;
    ctrl_mask     = 4'h0;
    case (state)
      IDLE:     if (rd_req) state_next = fifo_empty ? RD_ISSUE : DRAIN;
      DRAIN:    if (fifo_empty) state_next = RD_ISSUE;
      RD_ISSUE: if (!ctrl_busy) state_next = RD_WAIT;
      RD_WAIT:  if (rd_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (state == RD_ISSUE) begin
      ctrl_in_valid = 1'b1;
      ctrl_addr     = rd_addr;
    end else if (drain_ok) begin
      ctrl_in_valid = 1'b1;
      ctrl_rw       = 1'b1;
      ctrl_addr     = fifo_addr[rd_ptr];
      ctrl_data_in  = fifo_data[rd_ptr];
      ctrl_mask     = fifo_sel[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      wr_level       <= '0;
      rd_addr        <= '0;
      timer          <= '0;
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= '0;
      rd_timeout_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
        fifo_sel[i]  <= '0;
      end
    end else begin
      state <= state_next;
      if (push) begin
        fifo_addr[wr_ptr] <= wbs_adr_i[ADDR_W-1:0];
        fifo_data[wr_ptr] <= wbs_dat_i;
        fifo_sel[wr_ptr]  <= wbs_sel_i;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   wr_level <= wr_level + 1'b1;
        2'b01:   wr_level <= wr_level - 1'b1;
        default: wr_level <= wr_level;
      endcase
      if (rd_req) rd_addr <= wbs_adr_i[ADDR_W-1:0];
      if (state == RD_ISSUE)     timer <= '0;
      else if (state == RD_WAIT) timer <= timer + 1'b1;
      wbs_ack_o <= push | rd_done;
      if (rd_done) wbs_dat_o <= ctrl_out_valid ? ctrl_data_out : 32'hDEAD_BEEF;
      if (rd_tmo) rd_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_sdram_bridge.sv
module tb_wb_sdram_bridge;
  localparam int ADDR_W     = 23;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_TIMEOUT = 15;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk, rst;
  logic              wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_dat_i, wbs_adr_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [ADDR_W-1:0] ctrl_addr;
  logic              ctrl_rw;
  logic [31:0]       ctrl_data_in;
  logic [3:0]        ctrl_mask;
  logic              ctrl_in_valid;
  logic              ctrl_busy;
  logic [31:0]       ctrl_data_out;
  logic              ctrl_out_valid;
  logic [LVL_W-1:0]  wr_level;
  logic              rd_timeout_err;

  wb_sdram_bridge #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_data_in(ctrl_data_in),
    .ctrl_mask(ctrl_mask), .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
    .ctrl_data_out(ctrl_data_out), .ctrl_out_valid(ctrl_out_valid),
    .wr_level(wr_level), .rd_timeout_err(rd_timeout_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Requests accepted by the controller, in order.
  logic              log_rw   [$];
  logic [ADDR_W-1:0] log_addr [$];
  logic [31:0]       log_data [$];
  logic [3:0]        log_mask [$];

  // ---------------- controller model ----------------
  logic [31:0] mem [int];
  int          resp_delay = 0;     // 0 = never answer
  logic [31:0] resp_data  = '0;
  logic [31:0] rd_val;
  int          rd_cd;
  int          issue_cyc = 0;
  int          ov_cyc = 0;

  initial begin
    ctrl_out_valid = 1'b0;
    ctrl_data_out  = '0;
    rd_cd          = 0;
    rd_val         = '0;
    forever begin
      @(posedge clk); #1;
      ctrl_out_valid = 1'b0;
      if (rst) rd_cd = 0;
      else if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          ctrl_out_valid = 1'b1;
          ctrl_data_out  = rd_val;
          ov_cyc         = cyc_cnt;
        end
      end
      @(negedge clk);
      if (!rst && ctrl_in_valid && !ctrl_busy) begin
        log_rw.push_back(ctrl_rw);
        log_addr.push_back(ctrl_addr);
        log_data.push_back(ctrl_data_in);
        log_mask.push_back(ctrl_mask);
        if (ctrl_rw) mem[int'(ctrl_addr)] = ctrl_data_in;
        else begin
          rd_val    = mem.exists(int'(ctrl_addr)) ? mem[int'(ctrl_addr)] : resp_data;
          rd_cd     = resp_delay;
          issue_cyc = cyc_cnt;
        end
      end
    end
  end

  task automatic clear_log();
    log_rw.delete(); log_addr.delete(); log_data.delete(); log_mask.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output int ack_cyc);
    int start, n;
    bit ok;
    @(posedge clk); #1;
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1; wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    start = cyc_cnt; n = 0; ok = 0;
    while (n < 60 && !ok) begin
      @(negedge clk); n++;
      if (wbs_ack_o) ok = 1;
    end
    if (!ok) chk("wr_ack_timeout", 0, 1);
    ack_cyc = cyc_cnt; lat = cyc_cnt - start;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output int ack_cyc);
    int n;
    bit ok;
    @(posedge clk); #1;
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = a; wbs_sel_i = 4'hF;
    n = 0; ok = 0;
    while (n < 100 && !ok) begin
      @(negedge clk); n++;
      if (wbs_ack_o) ok = 1;
    end
    if (!ok) chk("rd_ack_timeout", 0, 1);
    ack_cyc = cyc_cnt; d = wbs_dat_o;
    wbs_stb_i = 0; wbs_cyc_i = 0;
  endtask

  task automatic wait_drained();
    int n = 0;
    while (n < 50 && (wr_level != 0 || ctrl_in_valid)) begin
      @(negedge clk); n++;
    end
    if (n >= 50) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, {ctrl_data_in, wbs_dat_o}, 64'h0);
    chk({tag, "_ctl"}, {29'h0, wbs_ack_o, ctrl_addr, ctrl_rw, ctrl_mask, ctrl_in_valid,
                         wr_level, rd_timeout_err}, 64'h0);
  endtask

  task automatic no_spurious(input string tag);
    int spur = 0;
    repeat (8) begin
      @(negedge clk);
      if (wbs_ack_o || ctrl_in_valid) spur++;
    end
    chk(tag, spur, 0);
    chk({tag, "_lvl"}, wr_level, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, ack_cyc, ack5, drop_cyc;
    logic [31:0] rd;
    rst = 1; ctrl_busy = 0;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_dat_i = 0; wbs_adr_i = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 0;

    // 1: single write with an idle controller
    clear_log();
    wb_write(32'h10, 32'hA5A5_0001, 4'hF, lat, ack_cyc);
    chk("t1_ack_lat", lat, 1);
    chk("t1_lvl1", wr_level, 1);
    chk("t1_req", {ctrl_in_valid, ctrl_rw, 28'h0, 9'h0, ctrl_addr}, {2'b11, 28'h0, 9'h0, 23'h10});
    chk("t1_data", {ctrl_data_in, 28'h0, ctrl_mask}, {32'hA5A5_0001, 28'h0, 4'hF});
    @(negedge clk);
    chk("t1_lvl0", wr_level, 0);
    chk("t1_log", log_rw.size(), 1);

    // 2: five writes against a busy controller
    clear_log();
    ctrl_busy = 1;
    for (int i = 0; i < 4; i++) begin
      wb_write(32'h100 + 4 * i, 32'hB000_0000 + i, 4'h3, lat, ack_cyc);
      chk($sformatf("t2_lat%0d", i), lat, 1);
    end
    fork
      wb_write(32'h110, 32'hB000_0004, 4'h3, lat, ack5);
      begin
        repeat (5) @(negedge clk);
        chk("t2_full_lvl", wr_level, 4);
        chk("t2_stalled", wbs_ack_o, 0);
        @(posedge clk); #1;
        ctrl_busy = 0;
        drop_cyc = cyc_cnt;
      end
    join
    chk("t2_ack5_after_drop", ack5 - drop_cyc, 2);
    wait_drained();
    chk("t2_log_n", log_rw.size(), 5);
    for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
      chk($sformatf("t2_order%0d", i), {log_data[i], 9'h0, log_addr[i]},
          {32'hB000_0000 + i, 9'h0, 23'h100 + 23'(4 * i)});
    end

    // 3: posted writes, then read of the last written address
    clear_log();
    resp_delay = 3;
    ctrl_busy  = 1;
    wb_write(32'h20, 32'h1111_0020, 4'hF, lat, ack_cyc);
    wb_write(32'h24, 32'h2222_0024, 4'hC, lat, ack_cyc);
    wb_write(32'h28, 32'h3333_0028, 4'hF, lat, ack_cyc);
    fork
      wb_read(32'h28, rd, ack_cyc);
      begin
        repeat (4) @(negedge clk);
        chk("t3_lvl3", wr_level, 3);
        chk("t3_no_read_yet", log_rw.size(), 0);
        @(posedge clk); #1;
        ctrl_busy = 0;
      end
    join
    chk("t3_rd_data", rd, 32'h3333_0028);
    chk("t3_log_n", log_rw.size(), 4);
    if (log_rw.size() == 4) begin
      chk("t3_seq_rw", {log_rw[0], log_rw[1], log_rw[2], log_rw[3]}, 4'b1110);
      chk("t3_rd_req", {log_mask[3], 9'h0, log_addr[3]}, {4'h0, 9'h0, 23'h28});
    end

    // 4: read answered after 7 cycles
    resp_delay = 7; resp_data = 32'h1234_5678;
    wb_read(32'h200, rd, ack_cyc);
    chk("t4_data", rd, 32'h1234_5678);
    chk("t4_ack_after_ov", ack_cyc - ov_cyc, 1);
    chk("t4_ack_after_issue", ack_cyc - issue_cyc, 8);
    chk("t4_err", rd_timeout_err, 0);
    wb_write(32'h300, 32'h5555_0300, 4'hF, lat, ack_cyc);
    chk("t4_dat_hold", wbs_dat_o, 32'h1234_5678);
    wait_drained();

    // 4b: data arriving on the timeout cycle wins
    resp_delay = RD_TIMEOUT + 1; resp_data = 32'hCAFE_0016;
    wb_read(32'h204, rd, ack_cyc);
    chk("t4b_data", rd, 32'hCAFE_0016);
    chk("t4b_ack_after_issue", ack_cyc - issue_cyc, RD_TIMEOUT + 2);
    chk("t4b_err", rd_timeout_err, 0);

    // 5: controller never answers
    resp_delay = 0;
    wb_read(32'h208, rd, ack_cyc);
    chk("t5_data", rd, 32'hDEAD_BEEF);
    chk("t5_ack_after_issue", ack_cyc - issue_cyc, RD_TIMEOUT + 2);
    chk("t5_err", rd_timeout_err, 1);
    resp_delay = 2; resp_data = 32'h0BAD_F00D;
    wb_read(32'h20C, rd, ack_cyc);
    chk("t5_next_data", rd, 32'h0BAD_F00D);
    chk("t5_err_sticky", rd_timeout_err, 1);

    // 6a: reset with two writes queued and a read waiting behind them
    ctrl_busy = 1;
    wb_write(32'h40, 32'h4444_0040, 4'hF, lat, ack_cyc);
    wb_write(32'h44, 32'h4444_0044, 4'hF, lat, ack_cyc);
    chk("t6_lvl2", wr_level, 2);
    @(posedge clk); #1;
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h48;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1 check_all_zero("t6a_rst");
    wbs_stb_i = 0; wbs_cyc_i = 0; ctrl_busy = 0;
    @(negedge clk); rst = 0;
    no_spurious("t6a_post");

    // 6b: reset while a read is waiting for data
    resp_delay = 0;
    @(posedge clk); #1;
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h50;
    repeat (4) @(negedge clk);
    #2 rst = 1;
    #1 check_all_zero("t6b_rst");
    wbs_stb_i = 0; wbs_cyc_i = 0;
    @(negedge clk); rst = 0;
    no_spurious("t6b_post");
    wb_write(32'h60, 32'h6666_0060, 4'hF, lat, ack_cyc);
    chk("t6b_recover_lat", lat, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
